// File: rtl/main_ctrl_fsm_pkg.sv
// Shared constants for the multicycle main control unit: opcodes, the
// controller state encoding, and the ALU/mux select codes that the
// datapath and ALU_ctrl decode.
package main_ctrl_fsm_pkg;

  // Supported instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU_op codes, shared with ALU_ctrl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC input select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; codes 12..15 are unreachable
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // State that follows DECODE for a given opcode; unsupported opcodes
  // return to FETCH (the caller flags them as illegal).
  function automatic state_t decode_target(input logic [5:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXEC;
      OP_BEQ:       s = S_BRANCH;
      OP_ADDI:      s = S_ADDIEX;
      OP_J:         s = S_JUMP;
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Bus between the datapath (master) and the main controller (slave).
// Memory handshake: the controller holds mem_read or mem_write high and a
// state that needs memory does not advance until a cycle in which
// mem_ready is 1; that cycle completes the access. mem_ready has no
// meaning in states that issue no memory request.
interface main_ctrl_fsm_if;
  import main_ctrl_fsm_pkg::*;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       PC_write;
  logic       PC_write_cond;
  logic       IorD;
  logic       mem_read;
  logic       mem_write;
  logic       IR_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       ALU_src_A;
  logic [1:0] ALU_src_B;
  logic [1:0] PC_source;
  logic [1:0] ALU_op;
  logic       illegal_op;
  state_t     dbg_state;

  modport master (
    output opcode, mem_ready,
    input  PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write,
           mem_to_reg, reg_write, reg_dst, ALU_src_A, ALU_src_B, PC_source,
           ALU_op, illegal_op, dbg_state
  );

  modport slave (
    input  opcode, mem_ready,
    output PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write,
           mem_to_reg, reg_write, reg_dst, ALU_src_A, ALU_src_B, PC_source,
           ALU_op, illegal_op, dbg_state
  );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Multicycle Moore main controller. Outputs are decoded from the state
// register alone, except IR_write/PC_write in FETCH which are qualified by
// mem_ready so the instruction and PC+4 are captured only when the fetch
// completes. The current state is exported on bus.dbg_state.
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  main_ctrl_fsm_if.slave  bus
);

  state_t     state;
  state_t     state_nx;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic [1:0] alu_op;
  logic       illegal_op;

  // State register; reset wins over every transition, including memory waits
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  // Next-state and Moore output decode; everything defaults to 0
  always_comb begin
    state_nx      = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        state_nx  = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded
        alu_src_b  = SRCB_IMM_SH2;
        state_nx   = decode_target(bus.opcode);
        illegal_op = !is_legal(bus.opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nx  = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_nx = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_nx  = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_nx  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nx  = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      // Unreachable encodings: all outputs stay 0, recover to FETCH
      default: state_nx = S_FETCH;
    endcase
  end

  assign bus.PC_write      = pc_write;
  assign bus.PC_write_cond = pc_write_cond;
  assign bus.IorD          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.IR_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.ALU_src_A     = alu_src_a;
  assign bus.ALU_src_B     = alu_src_b;
  assign bus.PC_source     = pc_source;
  assign bus.ALU_op        = alu_op;
  assign bus.illegal_op    = illegal_op;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Bench for main_ctrl_fsm: per-cycle vector table plus hand-written reset
// corner cases and randomized fetch stalls. Control word bit order:
// [16] PC_write [15] PC_write_cond [14] IorD [13] mem_read [12] mem_write
// [11] IR_write [10] mem_to_reg [9] reg_write [8] reg_dst [7] ALU_src_A
// [6:5] ALU_src_B [4:3] PC_source [2:1] ALU_op [0] illegal_op
module tb_main_ctrl_fsm;
  import main_ctrl_fsm_pkg::*;

  localparam int W = 21;

  // Expected control words per state, written from the output table
  localparam logic [16:0] C_F0     = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_F1     = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DEC_IL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [16:0] C_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BR     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_AIEX   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_AIWB   = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
  localparam logic [16:0] C_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;

  typedef struct {
    logic        r;
    logic        mr;
    logic [5:0]  op;
    logic        chk;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  main_ctrl_fsm_if bus ();

  main_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  vec_t           vecs[$];
  logic [W-1:0]   exp_q[$];
  int             n_cmp = 0;
  int             n_bad = 0;

  function automatic logic [W-1:0] observed();
    return {bus.dbg_state, bus.PC_write, bus.PC_write_cond, bus.IorD,
            bus.mem_read, bus.mem_write, bus.IR_write, bus.mem_to_reg,
            bus.reg_write, bus.reg_dst, bus.ALU_src_A, bus.ALU_src_B,
            bus.PC_source, bus.ALU_op, bus.illegal_op};
  endfunction

  task automatic add(input logic r, input logic mr, input logic [5:0] op,
                     input logic chk, input logic [3:0] st,
                     input logic [16:0] ctl);
    vec_t v;
    v.r = r; v.mr = mr; v.op = op; v.chk = chk; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs after the falling edge, queue the expected
  // outputs, then compare shortly after (well before the next rising edge)
  task automatic step(input logic r, input logic mr, input logic [5:0] op,
                      input logic chk, input logic [3:0] st,
                      input logic [16:0] ctl, input string tag);
    logic [W-1:0] got;
    logic [W-1:0] e;
    @(negedge clk);
    rst           = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    if (chk) exp_q.push_back({st, ctl});
    #1;
    if (chk) begin
      got = observed();
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: state/ctl got %h_%05h required %h_%05h",
                 tag, got[20:17], got[16:0], e[20:17], e[16:0]);
      end
    end
  endtask

  initial begin
    int nstall;
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_RTYPE;

    // Reset: first cycle state undefined, second shows FETCH
    add(1, 1, OP_LW,    0, S_FETCH,  C_F1);
    add(1, 1, OP_LW,    1, S_FETCH,  C_F1);
    // lw, mem_ready=1: 5 cycles, write-back only in cycle 5
    add(0, 1, OP_LW,    1, S_FETCH,  C_F1);
    add(0, 1, OP_LW,    1, S_DECODE, C_DEC);
    add(0, 1, OP_LW,    1, S_MEMADR, C_MADR);
    add(0, 1, OP_LW,    1, S_MEMRD,  C_MRD);
    add(0, 1, OP_LW,    1, S_MEMWB,  C_MWB);
    // R-format: 4 cycles
    add(0, 1, OP_RTYPE, 1, S_FETCH,  C_F1);
    add(0, 1, OP_RTYPE, 1, S_DECODE, C_DEC);
    add(0, 1, OP_RTYPE, 1, S_EXEC,   C_EXEC);
    add(0, 1, OP_RTYPE, 1, S_ALUWB,  C_ALUWB);
    // sw with 3 wait cycles in MEMWR: mem_write held 4 cycles
    add(0, 1, OP_SW,    1, S_FETCH,  C_F1);
    add(0, 1, OP_SW,    1, S_DECODE, C_DEC);
    add(0, 1, OP_SW,    1, S_MEMADR, C_MADR);
    add(0, 0, OP_SW,    1, S_MEMWR,  C_MWR);
    add(0, 0, OP_SW,    1, S_MEMWR,  C_MWR);
    add(0, 0, OP_SW,    1, S_MEMWR,  C_MWR);
    add(0, 1, OP_SW,    1, S_MEMWR,  C_MWR);
    // beq: 3 cycles
    add(0, 1, OP_BEQ,   1, S_FETCH,  C_F1);
    add(0, 1, OP_BEQ,   1, S_DECODE, C_DEC);
    add(0, 1, OP_BEQ,   1, S_BRANCH, C_BR);
    // illegal opcode: flagged in DECODE only, then FETCH
    add(0, 1, 6'h3f,    1, S_FETCH,  C_F1);
    add(0, 1, 6'h3f,    1, S_DECODE, C_DEC_IL);
    add(0, 0, 6'h3f,    1, S_FETCH,  C_F0);
    // fetch stall then addi: 4 cycles
    add(0, 0, OP_ADDI,  1, S_FETCH,  C_F0);
    add(0, 1, OP_ADDI,  1, S_FETCH,  C_F1);
    add(0, 1, OP_ADDI,  1, S_DECODE, C_DEC);
    add(0, 1, OP_ADDI,  1, S_ADDIEX, C_AIEX);
    add(0, 1, OP_ADDI,  1, S_ADDIWB, C_AIWB);
    // j: 3 cycles
    add(0, 1, OP_J,     1, S_FETCH,  C_F1);
    add(0, 1, OP_J,     1, S_DECODE, C_DEC);
    add(0, 1, OP_J,     1, S_JUMP,   C_JMP);
    // opcode sampled in DECODE and MEMADR only: lw decoded, sw at MEMADR
    add(0, 1, OP_RTYPE, 1, S_FETCH,  C_F1);
    add(0, 1, OP_LW,    1, S_DECODE, C_DEC);
    add(0, 1, OP_SW,    1, S_MEMADR, C_MADR);
    add(0, 1, OP_RTYPE, 1, S_MEMWR,  C_MWR);
    // lw with opcode changed during MEMRD: still write-back
    add(0, 1, OP_LW,    1, S_FETCH,  C_F1);
    add(0, 1, OP_LW,    1, S_DECODE, C_DEC);
    add(0, 1, OP_LW,    1, S_MEMADR, C_MADR);
    add(0, 0, OP_J,     1, S_MEMRD,  C_MRD);
    add(0, 1, OP_BEQ,   1, S_MEMRD,  C_MRD);
    add(0, 1, OP_BEQ,   1, S_MEMWB,  C_MWB);

    foreach (vecs[i])
      step(vecs[i].r, vecs[i].mr, vecs[i].op, vecs[i].chk, vecs[i].st,
           vecs[i].ctl, $sformatf("vec%0d", i));

    // Reset in the second MEMRD wait cycle -> FETCH with mem_read, IorD=0
    step(0, 1, OP_LW, 1, S_FETCH,  C_F1,   "rdrst_fetch");
    step(0, 1, OP_LW, 1, S_DECODE, C_DEC,  "rdrst_decode");
    step(0, 1, OP_LW, 1, S_MEMADR, C_MADR, "rdrst_memadr");
    step(0, 0, OP_LW, 1, S_MEMRD,  C_MRD,  "rdrst_wait1");
    step(1, 0, OP_LW, 1, S_MEMRD,  C_MRD,  "rdrst_wait2");
    step(0, 0, OP_LW, 1, S_FETCH,  C_F0,   "rdrst_refetch");

    // Reset during a MEMWR wait -> FETCH, no write enables
    step(0, 1, OP_SW, 1, S_FETCH,  C_F1,   "wrrst_fetch");
    step(0, 1, OP_SW, 1, S_DECODE, C_DEC,  "wrrst_decode");
    step(0, 1, OP_SW, 1, S_MEMADR, C_MADR, "wrrst_memadr");
    step(0, 0, OP_SW, 1, S_MEMWR,  C_MWR,  "wrrst_wait1");
    step(1, 0, OP_SW, 1, S_MEMWR,  C_MWR,  "wrrst_wait2");
    step(0, 1, OP_SW, 1, S_FETCH,  C_F1,   "wrrst_refetch");

    // Reset held in DECODE overrides the opcode-driven transition
    step(1, 1, OP_J,  1, S_DECODE, C_DEC,  "decrst_decode");
    step(0, 1, OP_J,  1, S_FETCH,  C_F1,   "decrst_fetch");

    // Randomized fetch stalls followed by a jump
    for (int k = 0; k < 6; k++) begin
      nstall = $urandom_range(0, 3);
      step(0, 1, OP_J, 1, S_DECODE, C_DEC, "rnd_decode");
      step(0, 0, OP_J, 1, S_JUMP,   C_JMP, "rnd_jump");
      for (int s = 0; s < nstall; s++)
        step(0, 0, OP_J, 1, S_FETCH, C_F0, "rnd_stall");
      step(0, 1, OP_J, 1, S_FETCH,  C_F1,  "rnd_fetch");
    end

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: queue depth %0d required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 No parameters; opcode and state encodings are package constants.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
REQ-006 PC_write  out  1  unconditional PC load.
REQ-007 PC_write_cond  out  1  PC load qualified by ALU zero (beq).
REQ-008 IorD  out  1  memory address select: 0=PC, 1=ALU out.
REQ-009 mem_read  out  1  memory read request.
REQ-010 mem_write  out  1  memory write request.
REQ-011 IR_write  out  1  instruction register load.
REQ-012 mem_to_reg  out  1  write-back select: 1=memory data, 0=ALU out.
REQ-013 reg_write  out  1  register file write enable.
REQ-014 reg_dst  out  1  destination: 1=rd, 0=rt.
REQ-015 ALU_src_A  out  1  ALU A: 0=PC, 1=rs.
REQ-016 ALU_src_B  out  2  ALU B: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-017 PC_source  out  2  PC input: 00=ALU result, 01=ALU out reg, 10=jump target.
REQ-018 ALU_op  out  2  to ALU_ctrl: 00=add, 01=sub, 10=R-format (decode funct).
REQ-019 illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-020 Multicycle Moore FSM, one state register; outputs are decoded from state only, except the mem_ready qualification in REQ-021; unlisted outputs are 0 in every state.
REQ-021 FETCH: mem_read=1, IorD=0, ALU_src_A=0, ALU_src_B=01, ALU_op=00, PC_source=00, IR_write=PC_write=mem_ready; stays while mem_ready=0, else goes to DECODE.
REQ-022 DECODE: ALU_src_A=0, ALU_src_B=11, ALU_op=00; next by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->FETCH with illegal_op=1 during DECODE.
REQ-023 MEMADR: ALU_src_A=1, ALU_src_B=10, ALU_op=00; goes to MEMRD if opcode=100011, else MEMWR.
REQ-024 MEMRD: mem_read=1, IorD=1; holds until mem_ready=1, then goes to MEMWB.
REQ-025 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; goes to FETCH.
REQ-026 MEMWR: mem_write=1, IorD=1; holds until mem_ready=1, then goes to FETCH.
REQ-027 EXEC: ALU_src_A=1, ALU_src_B=00, ALU_op=10; goes to ALUWB; ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; goes to FETCH.
REQ-028 BRANCH: ALU_src_A=1, ALU_src_B=00, ALU_op=01, PC_write_cond=1, PC_source=01; goes to FETCH.
REQ-029 ADDIEX: ALU_src_A=1, ALU_src_B=10, ALU_op=00; goes to ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; goes to FETCH.
REQ-030 JUMP: PC_write=1, PC_source=10; goes to FETCH.
REQ-031 Latency with mem_ready tied to 1: lw=5, sw=4, R/addi=4, beq=3, j=3, illegal=2 cycles.
REQ-032 opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
REQ-033 An unreachable state encoding goes to FETCH on the next edge with all outputs 0.

Reset
REQ-034 rst=1 at a clk edge loads FETCH regardless of state, including mid-MEMRD/MEMWR wait; rst takes priority over all transitions.
REQ-035 While in reset-entered FETCH, all outputs follow REQ-021; mem_write, reg_write, PC_write_cond and illegal_op are 0.

Structure
REQ-036 The shared package holds the opcode constants, the 4-bit state enum (12 states) and the ALU_op codes that ALU_ctrl also uses.
REQ-037 Single flat module, no sub-modules; one sequential state process and one combinational next-state/output process.

Verification
REQ-038 rst, mem_ready=1, opcode=100011 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-039 opcode=000000 -> ALU_op=10 in cycle 3, reg_write=1 with reg_dst=1 in cycle 4, then FETCH.
REQ-040 opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 held 4 cycles, no reg_write, then FETCH.
REQ-041 opcode=000100 -> ALU_op=01, PC_write_cond=1, PC_source=01 in cycle 3 only.
REQ-042 opcode=111111 -> illegal_op=1 for exactly the DECODE cycle, then FETCH with no write enables.
REQ-043 rst=1 in the second MEMRD wait cycle -> FETCH on the next edge, mem_read=1, IorD=0.
